load_wb_unit: RTL and testbench

Load execution and writeback sequencer that sits directly upstream of the register file write port. It accepts a decoded load, issues a word read to data memory over a valid/ready request plus valid response interface, and extracts and extends the addressed byte/half/word. It then presents a single-cycle write (data, rd, enable) to the register file. While a load is outstanding, `load_busy` drives the register file's load-enable input, which blocks other writes.

---
 rtl/load_wb_unit.sv | 169 ++++++++++++++++
 tb/tb_load_wb_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_wb_unit.sv
// load_wb_unit: load execution and writeback sequencer.
// Accepts a decoded load, reads the containing word from data memory,
// extracts/extends the addressed byte, half or word, then presents a
// single-cycle write to the register file.
//
// Handshake semantics: a memory request transfers on a cycle where
// mem_req_valid && mem_req_ready are both high at the rising edge; while
// mem_req_valid is high and mem_req_ready is low, mem_req_valid and
// mem_addr stay stable. The response side has no ready: mem_resp_valid
// is sampled only in WAIT (earliest the cycle after the request transfer)
// and is ignored in every other state.
module load_wb_unit #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    output logic        ld_ready,
    output logic        load_busy,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        ld_err,
    output logic [1:0]  dbgState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } loadStateT;

    loadStateT   state;
    loadStateT   stateNext;
    logic        errNext;
    logic        errQ;
    logic        badReq;
    logic        timeoutHit;
    logic [31:0] addrQ;
    logic [2:0]  funct3Q;
    logic [4:0]  rdQ;
    logic [31:0] dataQ;
    logic [CNT_W-1:0] cntQ;

    // Pick the addressed lane out of the little-endian word and extend it.
    function automatic logic [31:0] extractLoad(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [7:0]  byteVal;
        logic [15:0] halfVal;
        logic [31:0] res;
        byteVal = word[{off, 3'b000} +: 8];
        halfVal = word[{off[1], 4'b0000} +: 16];
        case (f3)
            3'd0:    res = {{24{byteVal[7]}}, byteVal};
            3'd4:    res = {24'd0, byteVal};
            3'd1:    res = {{16{halfVal[15]}}, halfVal};
            3'd5:    res = {16'd0, halfVal};
            default: res = word;
        endcase
        return res;
    endfunction

    // Classify the incoming request: illegal funct3 or misaligned access.
    always_comb begin
        badReq = 1'b0;
        case (funct3)
            3'd0, 3'd4: badReq = 1'b0;
            3'd1, 3'd5: badReq = addr[0];
            3'd2:       badReq = |addr[1:0];
            default:    badReq = 1'b1;
        endcase
    end

    assign timeoutHit = (cntQ == CNT_W'(TIMEOUT_CYCLES - 1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic; errNext marks the cycle before an ld_err pulse.
    always_comb begin
        stateNext = state;
        errNext   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (badReq) begin
                        errNext = 1'b1;
                    end else begin
                        stateNext = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    stateNext = WB;
                end else if (timeoutHit) begin
                    stateNext = IDLE;
                    errNext   = 1'b1;
                end
            end
            WB: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Request fields, timeout counter, extracted data and the error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addrQ   <= '0;
            funct3Q <= '0;
            rdQ     <= '0;
            dataQ   <= '0;
            cntQ    <= '0;
            errQ    <= 1'b0;
        end else begin
            errQ <= errNext;
            if (state == IDLE && start) begin
                addrQ   <= addr;
                funct3Q <= funct3;
                rdQ     <= rd;
            end
            if (state == REQ && mem_req_ready) begin
                cntQ <= '0;
            end else if (state == WAIT && !mem_resp_valid) begin
                cntQ <= cntQ + CNT_W'(1);
            end
            if (state == WAIT && mem_resp_valid) begin
                dataQ <= extractLoad(funct3Q, addrQ[1:0], mem_rdata);
            end
        end
    end

    assign ld_ready      = (state == IDLE);
    assign load_busy     = (state == REQ) || (state == WAIT);
    assign mem_req_valid = (state == REQ);
    assign mem_addr      = (state == REQ) ? {addrQ[31:2], 2'b00} : 32'd0;
    assign wb_en         = (state == WB) && (rdQ != 5'd0);
    assign wb_rd         = wb_en ? rdQ : 5'd0;
    assign wb_data       = wb_en ? dataQ : 32'd0;
    assign ld_err        = errQ;
    assign dbgState      = state;

endmodule

// File: tb/tb_load_wb_unit.sv
// Bench for load_wb_unit: directed vector table, hand sequences for
// reset/timeout corners, and randomized loads against a reference model.
module tb_load_wb_unit;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] addr;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        ld_ready;
    logic        load_busy;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ld_err;
    logic [1:0]  dbgState;

    int checks = 0;
    int passes = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [4:0]  r;
        logic [31:0] w;
        int          rdy;
        int          rsp;
        bit          noise;
        bit          expErr;
        logic [31:0] expData;
    } vecT;

    vecT vecs[$];

    load_wb_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .funct3(funct3), .rd(rd),
        .ld_ready(ld_ready), .load_busy(load_busy), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .ld_err(ld_err), .dbgState(dbgState)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what a load should return, from the ISA rules.
    function automatic void ref_load(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] w, output bit err,
                                     output logic [31:0] d);
        longint v;
        err = 1'b0;
        d   = '0;
        case (f3)
            3'd0, 3'd4: begin
                v = longint'((w >> (8 * int'(a[1:0]))) & 32'hFF);
                if (f3 == 3'd0 && v >= 128) v = v - 256;
                d = 32'(v);
            end
            3'd1, 3'd5: begin
                if (a[0]) begin
                    err = 1'b1;
                end else begin
                    v = longint'((w >> (16 * int'(a[1]))) & 32'hFFFF);
                    if (f3 == 3'd1 && v >= 32768) v = v - 65536;
                    d = 32'(v);
                end
            end
            3'd2: begin
                if (a[1:0] != 2'b00) err = 1'b1;
                else d = w;
            end
            default: err = 1'b1;
        endcase
    endfunction

    function automatic vecT mk(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] r,
                               input logic [31:0] w, input int rdy, input int rsp,
                               input bit noise, input bit expErr, input logic [31:0] expData);
        vecT v;
        v.f3 = f3; v.a = a; v.r = r; v.w = w; v.rdy = rdy; v.rsp = rsp;
        v.noise = noise; v.expErr = expErr; v.expData = expData;
        return v;
    endfunction

    // Drive one complete load starting at a negedge with the unit idle.
    // rsp >= TO means no response is given (timeout expected).
    task automatic do_load(input vecT v);
        logic [31:0] wa;
        logic [31:0] got;
        wa = {v.a[31:2], 2'b00};
        start = 1'b1; addr = v.a; funct3 = v.f3; rd = v.r;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; addr = $urandom; funct3 = 3'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 31));
        if (v.expErr) begin
            check("err_pulse", ld_err, 1);
            check("err_noreq", mem_req_valid, 0);
            check("err_idle", ld_ready, 1);
            @(negedge clk);
            check("err_single", ld_err, 0);
            check("err_nowb", wb_en, 0);
            check("err_noreq2", mem_req_valid, 0);
            return;
        end
        check("req_valid", mem_req_valid, 1);
        check("req_busy", load_busy, 1);
        check("req_addr", mem_addr, wa);
        check("req_notready", ld_ready, 0);
        for (int i = 0; i < v.rdy; i++) begin
            if (v.noise) begin
                start = 1'b1; addr = $urandom; mem_resp_valid = 1'b1; mem_rdata = $urandom;
            end
            @(negedge clk);
            start = 1'b0; mem_resp_valid = 1'b0;
            check("req_hold", mem_req_valid, 1);
            check("req_addr_hold", mem_addr, wa);
        end
        mem_req_ready = 1'b1;
        if (v.noise) begin
            mem_resp_valid = 1'b1; mem_rdata = $urandom;
        end
        @(negedge clk);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        check("wait_noreq", mem_req_valid, 0);
        check("wait_busy", load_busy, 1);
        if (v.rsp >= TO) begin
            for (int i = 0; i < TO - 1; i++) begin
                @(negedge clk);
                check("wait_busy_to", load_busy, 1);
                check("wait_noerr", ld_err, 0);
            end
            @(negedge clk);
            check("timeout_err", ld_err, 1);
            check("timeout_idle", ld_ready, 1);
            check("timeout_nowb", wb_en, 0);
            mem_resp_valid = 1'b1; mem_rdata = $urandom;
            @(negedge clk);
            mem_resp_valid = 1'b0;
            check("late_nowb", wb_en, 0);
            check("late_noerr", ld_err, 0);
            check("late_idle", ld_ready, 1);
            return;
        end
        if (v.r != 5'd0) exp_q.push_back(v.expData);
        for (int i = 0; i < v.rsp; i++) begin
            @(negedge clk);
            check("wait_hold", load_busy, 1);
            check("wait_nowb", wb_en, 0);
        end
        mem_resp_valid = 1'b1; mem_rdata = v.w;
        @(negedge clk);
        mem_resp_valid = 1'b0; mem_rdata = $urandom;
        check("wb_busy", load_busy, 0);
        check("wb_notready", ld_ready, 0);
        check("wb_en", wb_en, v.r != 5'd0);
        if (wb_en) begin
            check("wb_q_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                got = exp_q.pop_front();
                check("wb_data", wb_data, got);
                check("wb_rd", wb_rd, v.r);
            end
        end else begin
            check("wb_data_zero", wb_data, 0);
            check("wb_rd_zero", wb_rd, 0);
        end
        @(negedge clk);
        check("post_wb_idle", ld_ready, 1);
        check("post_wb_en", wb_en, 0);
        check("post_wb_data", wb_data, 0);
    endtask

    initial begin
        vecT rv;
        bit  e;
        logic [31:0] d;

        // Reset block.
        rst = 1'b0; start = 1'b0; addr = '0; funct3 = '0; rd = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", ld_ready, 1);
        check("rst_busy", load_busy, 0);
        check("rst_reqv", mem_req_valid, 0);
        check("rst_maddr", mem_addr, 0);
        check("rst_wben", wb_en, 0);
        check("rst_wbdata", wb_data, 0);
        check("rst_err", ld_err, 0);
        check("rst_state", dbgState, 0);
        rst = 1'b1;
        @(negedge clk);

        // Directed vector table.
        vecs.push_back(mk(3'd2, 32'h80000010, 5'd5,  32'hDEADBEEF, 0, 0, 0, 0, 32'hDEADBEEF));
        vecs.push_back(mk(3'd0, 32'h80000003, 5'd7,  32'h80FF7F01, 0, 0, 0, 0, 32'hFFFFFF80));
        vecs.push_back(mk(3'd4, 32'h80000003, 5'd8,  32'h80FF7F01, 1, 2, 0, 0, 32'h00000080));
        vecs.push_back(mk(3'd1, 32'h80000002, 5'd9,  32'h80FF7F01, 0, 1, 1, 0, 32'hFFFF80FF));
        vecs.push_back(mk(3'd5, 32'h80000002, 5'd10, 32'h80FF7F01, 2, 0, 1, 0, 32'h000080FF));
        vecs.push_back(mk(3'd0, 32'h80000001, 5'd11, 32'h80FF7F01, 0, 0, 0, 0, 32'h0000007F));
        vecs.push_back(mk(3'd0, 32'h80000002, 5'd12, 32'h80FF7F01, 0, 3, 0, 0, 32'hFFFFFFFF));
        vecs.push_back(mk(3'd1, 32'h80000000, 5'd13, 32'h80FF7F01, 0, 0, 0, 0, 32'h00007F01));
        vecs.push_back(mk(3'd2, 32'h80000002, 5'd1,  32'h0,        0, 0, 0, 1, 32'h0));
        vecs.push_back(mk(3'd1, 32'h80000001, 5'd1,  32'h0,        0, 0, 0, 1, 32'h0));
        vecs.push_back(mk(3'd3, 32'h80000000, 5'd1,  32'h0,        0, 0, 0, 1, 32'h0));
        vecs.push_back(mk(3'd6, 32'h80000000, 5'd1,  32'h0,        0, 0, 0, 1, 32'h0));
        vecs.push_back(mk(3'd7, 32'h80000000, 5'd1,  32'h0,        0, 0, 0, 1, 32'h0));
        vecs.push_back(mk(3'd5, 32'h80000003, 5'd1,  32'h0,        0, 0, 0, 1, 32'h0));
        vecs.push_back(mk(3'd2, 32'h80000020, 5'd14, 32'h12345678, 4, 4, 1, 0, 32'h12345678));
        vecs.push_back(mk(3'd2, 32'h80000030, 5'd3,  32'h0,        0, TO, 0, 0, 32'h0));
        vecs.push_back(mk(3'd2, 32'h80000040, 5'd0,  32'hCAFEF00D, 1, 1, 0, 0, 32'hCAFEF00D));
        foreach (vecs[i]) do_load(vecs[i]);

        // Async reset while waiting for a response.
        start = 1'b1; addr = 32'h80000050; funct3 = 3'd2; rd = 5'd6;
        @(negedge clk);
        start = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("arst_pre_busy", load_busy, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_ready", ld_ready, 1);
        check("arst_busy", load_busy, 0);
        check("arst_reqv", mem_req_valid, 0);
        check("arst_wben", wb_en, 0);
        check("arst_err", ld_err, 0);
        @(negedge clk);
        rst = 1'b1;
        mem_resp_valid = 1'b1; mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check("arst_stale_wb", wb_en, 0);
        check("arst_stale_err", ld_err, 0);
        check("arst_stale_idle", ld_ready, 1);
        @(negedge clk);
        check("arst_stale_wb2", wb_en, 0);

        // Randomized loads against the reference model.
        for (int n = 0; n < 60; n++) begin
            rv.f3 = 3'($urandom_range(0, 7));
            rv.a = $urandom;
            if (rv.f3 == 3'd2 && $urandom_range(0, 3) != 0) rv.a[1:0] = 2'b00;
            if ((rv.f3 == 3'd1 || rv.f3 == 3'd5) && $urandom_range(0, 3) != 0) rv.a[0] = 1'b0;
            rv.r = 5'($urandom_range(0, 31));
            rv.w = $urandom;
            rv.rdy = $urandom_range(0, 3);
            rv.rsp = $urandom_range(0, TO + 1);
            rv.noise = 1'($urandom_range(0, 1));
            ref_load(rv.f3, rv.a, rv.w, e, d);
            rv.expErr = e;
            rv.expData = d;
            do_load(rv);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
